tdm_demux4: RTL and testbench

Time-division demultiplexer, the receive-side counterpart of the 4:1 `mux4` lane selector. It accepts a serial stream of WIDTH-bit words, one slot per accepted beat, with slot 0 marked by a start-of-frame flag. It assembles four consecutive slots into lanes a/b/c/d and presents the complete frame on a registered valid/ready output. Framing errors trigger resynchronisation.

---
 rtl/tdm_demux4_if.sv | 29 ++
 rtl/tdm_demux4.sv | 133 +++++++++++++
 tb/tb_tdm_demux4.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_if.sv
// Bus bundle for tdm_demux4: serial slot input, framed four-lane output,
// and the debug/error status.
interface tdm_demux4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_sof;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       s;
    logic             frame_err;
    logic [7:0]       err_count;

    modport master (
        output in_data, in_sof, in_valid, out_ready,
        input  in_ready, out_a, out_b, out_c, out_d, out_valid, s, frame_err, err_count
    );

    modport slave (
        input  in_data, in_sof, in_valid, out_ready,
        output in_ready, out_a, out_b, out_c, out_d, out_valid, s, frame_err, err_count
    );
endinterface

// File: rtl/tdm_demux4.sv
// Time-division demultiplexer: assembles four slots (slot 0 flagged by sof) into lanes a..d.
// Define TDM_DEMUX_ERRCNT_EN to build the saturating framing-error counter.
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    tdm_demux4_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, COLLECT, ALIGNED} state_t;

    state_t           state, state_n;
    logic [1:0]       s, s_n;
    logic             in_ready, accept;
    logic             frame_err, frame_err_n;
    logic             load_frame;
    logic             stage_a_we, stage_b_we, stage_c_we;
    logic [WIDTH-1:0] stage_a, stage_b, stage_c;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic             out_valid;

    // Only the slot-3 word can stall: it needs the output buffer free.
    assign in_ready = !(state == COLLECT && s == 2'd3 && out_valid && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_n     = state;
        s_n         = s;
        frame_err_n = 1'b0;
        load_frame  = 1'b0;
        stage_a_we  = 1'b0;
        stage_b_we  = 1'b0;
        stage_c_we  = 1'b0;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (bus.in_sof) begin
                        stage_a_we = 1'b1;
                        s_n        = 2'd1;
                        state_n    = COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.in_sof) begin
                        frame_err_n = 1'b1;
                        stage_a_we  = 1'b1;
                        s_n         = 2'd1;
                    end else if (s == 2'd3) begin
                        load_frame = 1'b1;
                        s_n        = 2'd0;
                        state_n    = ALIGNED;
                    end else begin
                        stage_b_we = (s == 2'd1);
                        stage_c_we = (s == 2'd2);
                        s_n        = s + 2'd1;
                    end
                end
                ALIGNED: begin
                    if (bus.in_sof) begin
                        stage_a_we = 1'b1;
                        s_n        = 2'd1;
                        state_n    = COLLECT;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = HUNT;
                    end
                end
                default: begin
                    state_n = HUNT;
                    s_n     = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            s         <= 2'd0;
            frame_err <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            frame_err <= frame_err_n;
            if (load_frame) begin
                out_valid <= 1'b1;
                out_a     <= stage_a;
                out_b     <= stage_b;
                out_c     <= stage_c;
                out_d     <= bus.in_data;
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Staging is never exposed until a full frame lands, so it needs no reset.
    always_ff @(posedge clk) begin
        if (stage_a_we) stage_a <= bus.in_data;
        if (stage_b_we) stage_b <= bus.in_data;
        if (stage_c_we) stage_c <= bus.in_data;
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (frame_err_n && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    logic [7:0] err_count;
    assign err_count = 8'd0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_a     = out_a;
    assign bus.out_b     = out_b;
    assign bus.out_c     = out_c;
    assign bus.out_d     = out_d;
    assign bus.out_valid = out_valid;
    assign bus.s         = s;
    assign bus.frame_err = frame_err;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: a frame-level reference model feeds a scoreboard
// queue that a separate monitor drains on each output handshake.
module tb_tdm_demux4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: partial frame as a queue of words plus a hunting flag.
    logic [W-1:0]   m_part[$];
    bit             m_hunt = 1'b1;
    bit             m_ov   = 1'b0;
    logic [4*W-1:0] m_frame = '0;
    bit             m_err  = 1'b0;
    int             m_cnt  = 0;
    logic [4*W-1:0] exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit sof, input logic [W-1:0] d,
                                 input bit ordy, input bit r, output bit acc);
        bit             exp_ready;
        bit             load;
        bit             err;
        logic [4*W-1:0] frame;
        @(negedge clk);
        #1;
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
        checkOutput("out_lanes", {16'd0, bus.out_a, bus.out_b, bus.out_c, bus.out_d}, {16'd0, m_frame});
        checkOutput("frame_err", {31'd0, bus.frame_err}, {31'd0, m_err});
        checkOutput("err_count", {24'd0, bus.err_count}, m_cnt);
        checkOutput("slot_s", {30'd0, bus.s}, m_part.size());
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_data   = d;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        exp_ready = !(m_part.size() == 3 && m_ov && !ordy);
        checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        acc = v && exp_ready && !r;
        if (r) begin
            m_part.delete();
            m_hunt  = 1'b1;
            m_ov    = 1'b0;
            m_frame = '0;
            m_err   = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
            acc     = 1'b0;
        end else begin
            load  = 1'b0;
            err   = 1'b0;
            frame = '0;
            if (acc) begin
                if (sof) begin
                    if (m_part.size() != 0) err = 1'b1;
                    m_part.delete();
                    m_part.push_back(d);
                    m_hunt = 1'b0;
                end else if (m_hunt) begin
                    // discarded while hunting
                end else if (m_part.size() == 0) begin
                    err    = 1'b1;
                    m_hunt = 1'b1;
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == 4) begin
                        load  = 1'b1;
                        frame = {m_part[0], m_part[1], m_part[2], m_part[3]};
                        m_part.delete();
                    end
                end
            end
            if (load) begin
                m_ov    = 1'b1;
                m_frame = frame;
                exp_q.push_back(frame);
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            m_err = err;
`ifdef TDM_DEMUX_ERRCNT_EN
            if (err && m_cnt < 255) m_cnt++;
`endif
        end
    endtask

    task automatic sendWord(input bit sof, input logic [W-1:0] d, input bit ordy);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, sof, d, ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept of %0h", d);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, ordy, 1'b0, acc);
    endtask

    task automatic sendFrame(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d, input bit ordy);
        sendWord(1'b1, a, ordy);
        sendWord(1'b0, b, ordy);
        sendWord(1'b0, c, ordy);
        sendWord(1'b0, d, ordy);
    endtask

    // Monitor: pop and compare one expected frame per output handshake.
    initial begin
        logic [4*W-1:0] f;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL frame_unexpected: got %0h expected no frame",
                             {bus.out_a, bus.out_b, bus.out_c, bus.out_d});
                end else begin
                    f = exp_q.pop_front();
                    checkOutput("frame", {16'd0, bus.out_a, bus.out_b, bus.out_c, bus.out_d}, {16'd0, f});
                end
            end
        end
    end

    initial begin
        bit acc;
        int gen_slot;
        bit v, sof, ordy, r, corrupt;
        logic [W-1:0] d;

        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] clean and back-to-back frames");
        idle(2, 1'b1);
        sendFrame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        idle(2, 1'b1);
        sendFrame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        sendFrame(4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
        idle(2, 1'b1);

        $display("[TB] backpressure");
        sendFrame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        sendWord(1'b1, 4'h5, 1'b0);
        sendWord(1'b0, 4'h6, 1'b0);
        sendWord(1'b0, 4'h7, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h8, 1'b0, 1'b0, acc);
        sendWord(1'b0, 4'h8, 1'b1);
        idle(2, 1'b1);

        $display("[TB] early sof");
        sendWord(1'b1, 4'h1, 1'b1);
        sendWord(1'b0, 4'h2, 1'b1);
        sendFrame(4'h9, 4'hA, 4'hB, 4'hC, 1'b1);
        idle(2, 1'b1);

        $display("[TB] missing sof and hunt");
        sendFrame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        sendWord(1'b0, 4'h7, 1'b1);
        sendWord(1'b0, 4'h3, 1'b1);
        sendFrame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        idle(2, 1'b1);

        $display("[TB] reset mid-frame");
        sendWord(1'b1, 4'h1, 1'b1);
        sendWord(1'b0, 4'h2, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        sendWord(1'b0, 4'h3, 1'b1);
        sendFrame(4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
        idle(2, 1'b1);

        $display("[TB] randomized traffic");
        gen_slot = 0;
        for (int n = 0; n < 3000; n++) begin
            v       = ($urandom_range(0, 3) != 0);
            corrupt = ($urandom_range(0, 19) == 0);
            sof     = (gen_slot == 0) ^ corrupt;
            d       = W'($urandom);
            ordy    = ($urandom_range(0, 2) != 0);
            r       = ($urandom_range(0, 299) == 0);
            applyStimulus(v, sof, d, ordy, r, acc);
            if (r) gen_slot = 0;
            else if (acc) gen_slot = (gen_slot + 1) % 4;
        end

        idle(8, 1'b1);
        checkOutput("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
